qcom_reg_stab: RTL and testbench
================================

QCOM_REG_STAB -- requirements
Module: qcom_reg_stab

Interface
REQ-001 Parameter DW, default 32, data width in bits.
REQ-002 Parameter STB_CNT, default 4, number of consecutive identical samples needed to accept a value; legal range 2..255.
REQ-003 Parameter RST_VAL, default 0, DW-bit reset value of the accepted register.
REQ-004 Port: clk_i  input  1  single clock for the whole block.
REQ-005 Port: rst_ni  input  1  reset, asynchronous assertion, active-low.
REQ-006 Port: dt_i  input  DW  register value already brought into the clk_i domain by the two-flop synchronizer stage.
REQ-007 Port: dt_o  output  DW  last accepted (stable) value.
REQ-008 Port: upd_o  output  1  update valid; high while a newly accepted dt_o awaits acknowledge.
REQ-009 Port: upd_ack_i  input  1  consumer acknowledge of upd_o.
REQ-010 Port: chg_cnt_o  output  16  count of accepted updates.
REQ-011 Port: ovr_o  output  1  sticky overrun flag.
REQ-012 Port: ovr_clr_i  input  1  synchronous clear of ovr_o.

Function
REQ-013 The block SHALL hold an internal candidate register cand (DW bits), an 8-bit stability counter cnt, and a 3-state FSM: IDLE, SETTLE, HOLD.
REQ-014 IDLE: if dt_i != dt_o, then cand <= dt_i, cnt <= 1, go to SETTLE; else stay.
REQ-015 SETTLE, dt_i == dt_o: return to IDLE with no update (glitch rejection); takes priority over the other SETTLE rules.
REQ-016 SETTLE, dt_i != cand (and != dt_o): cand <= dt_i, cnt <= 1, stay in SETTLE (restart).
REQ-017 SETTLE, dt_i == cand and cnt < STB_CNT-1: cnt <= cnt+1.
REQ-018 SETTLE, dt_i == cand and cnt == STB_CNT-1: dt_o <= cand, upd_o <= 1, chg_cnt_o increments, go to HOLD.
REQ-019 Latency: a value first sampled at edge 0 and stable thereafter SHALL appear on dt_o with upd_o high after edge STB_CNT-1.
REQ-020 HOLD: upd_o and dt_o stay constant until upd_ack_i is sampled high; on that edge upd_o <= 0 and the FSM goes to IDLE.
REQ-021 upd_ack_i SHALL be ignored when upd_o is low.
REQ-022 In HOLD, dt_i is not tracked; a differing dt_i is evaluated from IDLE after the acknowledge, so no value is lost if it persists.
REQ-023 ovr_o SHALL be set on any edge in HOLD where dt_i != dt_o, and stays set until ovr_clr_i is sampled high.
REQ-024 If set and clear conditions occur on the same edge, set SHALL win.
REQ-025 chg_cnt_o SHALL saturate at 0xFFFF and never wrap.
REQ-026 All outputs SHALL be driven directly from registers.

Reset
REQ-027 While rst_ni is low: dt_o = RST_VAL, cand = RST_VAL, upd_o = 0, cnt = 0, chg_cnt_o = 0, ovr_o = 0, FSM = IDLE.
REQ-028 Reset asserted in any state, including SETTLE or HOLD, SHALL discard any pending candidate or unacknowledged update.
REQ-029 After release, the first edge SHALL evaluate dt_i against RST_VAL per REQ-014.

Verification
REQ-030 STB_CNT=4, dt_i 0 -> 0x0000_00A5 held -> upd_o rises after the 4th sampling edge, dt_o=0xA5, chg_cnt_o=1; ack on that cycle -> upd_o low next edge.
REQ-031 dt_i 0 -> 0x11 for 2 cycles -> 0 -> no upd_o, dt_o stays 0, chg_cnt_o unchanged.
REQ-032 dt_i 0 -> 0x11 (2 cycles) -> 0x22 held -> single update with dt_o=0x22, 4 edges after 0x22 first sampled; 0x11 never visible.
REQ-033 Update 0x22 pending without ack, dt_i -> 0x33 -> ovr_o=1, dt_o remains 0x22; ack -> 0x33 accepted 4 edges later; ovr_clr_i with a simultaneous HOLD mismatch -> ovr_o stays 1.
REQ-034 Reset pulse during SETTLE and during HOLD -> all outputs at reset values immediately (asynchronous), no spurious upd_o after release when dt_i == RST_VAL.
REQ-035 Force chg_cnt_o to 0xFFFE, perform 3 updates -> reads 0xFFFF.

Source files
------------

// File: rtl/qcom_reg_stab.sv
// Stabilizer for a multi-bit register value that arrives through a two-flop synchronizer.
// A new value is accepted only after STB_CNT identical samples. The block then holds the update until the consumer acknowledges it.
module qcom_reg_stab #(
   parameter int unsigned          DW      = 32,
   parameter int unsigned          STB_CNT = 4,
   parameter logic [DW-1:0]        RST_VAL = '0
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [DW-1:0] dt_i,
   output logic [DW-1:0] dt_o,
   output logic          upd_o,
   input  logic          upd_ack_i,
   output logic [15:0]   chg_cnt_o,
   output logic          ovr_o,
   input  logic          ovr_clr_i
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(STB_CNT - 1);

   state_t        r_state;
   logic [DW-1:0] r_cand;
   logic [7:0]    r_cnt;
   logic [DW-1:0] r_dt;
   logic          r_upd;
   logic [15:0]   r_chg_cnt;
   logic          r_ovr;

   logic          w_diff_out;
   logic          w_diff_cand;

   assign w_diff_out  = (dt_i != r_dt);
   assign w_diff_cand = (dt_i != r_cand);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ST_IDLE;
         r_cand    <= RST_VAL;
         r_cnt     <= '0;
         r_dt      <= RST_VAL;
         r_upd     <= 1'b0;
         r_chg_cnt <= '0;
         r_ovr     <= 1'b0;
      end else begin
         // The set condition is checked first, so it wins over a clear on the same edge.
         if ((r_state == ST_HOLD) && w_diff_out) begin
            r_ovr <= 1'b1;
         end else if (ovr_clr_i) begin
            r_ovr <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_diff_out) begin
                  r_cand  <= dt_i;
                  r_cnt   <= 8'd1;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (!w_diff_out) begin
                  r_cnt   <= '0;
                  r_state <= ST_IDLE;
               end else if (w_diff_cand) begin
                  r_cand <= dt_i;
                  r_cnt  <= 8'd1;
               end else if (r_cnt < CNT_LAST) begin
                  r_cnt <= r_cnt + 8'd1;
               end else begin
                  r_dt    <= r_cand;
                  r_upd   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= ST_HOLD;
                  if (r_chg_cnt != 16'hFFFF) begin
                     r_chg_cnt <= r_chg_cnt + 16'd1;
                  end
               end
            end
            ST_HOLD: begin
               if (r_upd && upd_ack_i) begin
                  r_upd   <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign dt_o      = r_dt;
   assign upd_o     = r_upd;
   assign chg_cnt_o = r_chg_cnt;
   assign ovr_o     = r_ovr;

endmodule

// File: tb/tb_qcom_reg_stab.sv
// Directed bench for qcom_reg_stab (DW=32, STB_CNT=4, RST_VAL=0).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_qcom_reg_stab;

   logic        clk_i;
   logic        rst_ni;
   logic [31:0] dt_i;
   logic [31:0] dt_o;
   logic        upd_o;
   logic        upd_ack_i;
   logic [15:0] chg_cnt_o;
   logic        ovr_o;
   logic        ovr_clr_i;

   int unsigned total;
   int unsigned bad;

   qcom_reg_stab #(
      .DW      (32),
      .STB_CNT (4),
      .RST_VAL (32'h0)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .dt_i      (dt_i),
      .dt_o      (dt_o),
      .upd_o     (upd_o),
      .upd_ack_i (upd_ack_i),
      .chg_cnt_o (chg_cnt_o),
      .ovr_o     (ovr_o),
      .ovr_clr_i (ovr_clr_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_rst(input string tag);
      check({tag, "_dt"},  dt_o, 32'h0);
      check({tag, "_upd"}, {31'd0, upd_o}, 32'd0);
      check({tag, "_chg"}, {16'd0, chg_cnt_o}, 32'd0);
      check({tag, "_ovr"}, {31'd0, ovr_o}, 32'd0);
   endtask

   // Hold v for four edges, check the accepted update, then acknowledge it.
   task automatic do_update(input string tag, input logic [31:0] v, input logic [15:0] exp_cnt);
      dt_i = v;
      repeat (3) tick();
      check({tag, "_early"}, {31'd0, upd_o}, 32'd0);
      tick();
      check({tag, "_upd"}, {31'd0, upd_o}, 32'd1);
      check({tag, "_dt"},  dt_o, v);
      check({tag, "_chg"}, {16'd0, chg_cnt_o}, {16'd0, exp_cnt});
      upd_ack_i = 1'b1;
      tick();
      upd_ack_i = 1'b0;
      check({tag, "_ack"}, {31'd0, upd_o}, 32'd0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_ni    = 1'b0;
      dt_i      = 32'h0;
      upd_ack_i = 1'b0;
      ovr_clr_i = 1'b0;
      #12;
      check_rst("reset");
      tick();
      rst_ni = 1'b1;
      repeat (3) tick();
      check_rst("idle_eq");

      // Basic acceptance of 0xA5 with latency STB_CNT edges.
      do_update("a5", 32'h0000_00A5, 16'd1);
      do_update("back0", 32'h0, 16'd2);

      // Two-cycle glitch returns to the accepted value: rejected.
      dt_i = 32'h11;
      repeat (2) tick();
      dt_i = 32'h0;
      repeat (4) tick();
      check("glitch_upd", {31'd0, upd_o}, 32'd0);
      check("glitch_dt",  dt_o, 32'h0);
      check("glitch_chg", {16'd0, chg_cnt_o}, 32'd2);

      // Glitch followed by a new stable value: only 0x22 is accepted.
      dt_i = 32'h11;
      repeat (2) tick();
      dt_i = 32'h22;
      repeat (3) tick();
      check("restart_early", {31'd0, upd_o}, 32'd0);
      check("restart_dt0",   dt_o, 32'h0);
      tick();
      check("restart_upd", {31'd0, upd_o}, 32'd1);
      check("restart_dt",  dt_o, 32'h22);
      check("restart_chg", {16'd0, chg_cnt_o}, 32'd3);

      // Overrun while the update is pending; set beats clear.
      dt_i = 32'h33;
      tick();
      check("ovr_set",  {31'd0, ovr_o}, 32'd1);
      check("ovr_hold_dt", dt_o, 32'h22);
      check("ovr_hold_upd", {31'd0, upd_o}, 32'd1);
      ovr_clr_i = 1'b1;
      tick();
      ovr_clr_i = 1'b0;
      check("ovr_set_wins", {31'd0, ovr_o}, 32'd1);
      upd_ack_i = 1'b1;
      tick();
      upd_ack_i = 1'b0;
      check("ovr_ack", {31'd0, upd_o}, 32'd0);
      repeat (3) tick();
      check("late_early", {31'd0, upd_o}, 32'd0);
      tick();
      check("late_upd", {31'd0, upd_o}, 32'd1);
      check("late_dt",  dt_o, 32'h33);
      check("late_chg", {16'd0, chg_cnt_o}, 32'd4);
      upd_ack_i = 1'b1;
      tick();
      upd_ack_i = 1'b0;
      ovr_clr_i = 1'b1;
      tick();
      ovr_clr_i = 1'b0;
      check("ovr_clr", {31'd0, ovr_o}, 32'd0);
      check("ack_idle_upd", {31'd0, upd_o}, 32'd0);

      // Asynchronous reset while settling.
      dt_i = 32'h44;
      repeat (2) tick();
      rst_ni = 1'b0;
      #1;
      check_rst("rst_settle");
      dt_i = 32'h0;
      tick();
      rst_ni = 1'b1;
      repeat (5) tick();
      check_rst("post_settle");

      // Asynchronous reset with an unacknowledged update and overrun.
      dt_i = 32'h55;
      repeat (4) tick();
      check("pre_hold_upd", {31'd0, upd_o}, 32'd1);
      dt_i = 32'h66;
      tick();
      check("pre_hold_ovr", {31'd0, ovr_o}, 32'd1);
      rst_ni = 1'b0;
      #1;
      check_rst("rst_hold");
      dt_i = 32'h0;
      tick();
      rst_ni = 1'b1;
      repeat (5) tick();
      check_rst("post_hold");

      // Counter saturation.
      force dut.r_chg_cnt = 16'hFFFE;
      tick();
      release dut.r_chg_cnt;
      tick();
      check("sat_start", {16'd0, chg_cnt_o}, 32'h0000_FFFE);
      do_update("sat1", 32'h1, 16'hFFFF);
      do_update("sat2", 32'h2, 16'hFFFF);
      do_update("sat3", 32'h3, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
